// File: rtl/accu_pkg.sv
// Shared types and constants for the 8-bit accumulator core control path.
package accu_pkg;

   localparam int OPC_W      = 4;
   localparam int REG_ADDR_W = 2;

   // Instruction byte: [7:4] opcode, [3:2] unused, [1:0] register index.
   typedef enum logic [OPC_W-1:0] {
      OP_NOP = 4'h0,
      OP_LD  = 4'h1,
      OP_ST  = 4'h2,
      OP_ADD = 4'h3,
      OP_SUB = 4'h4,
      OP_AND = 4'h5,
      OP_OR  = 4'h6,
      OP_XOR = 4'h7,
      OP_JMP = 4'h8,
      OP_JZ  = 4'h9,
      OP_HLT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_PASS_B = 3'd0,
      ALU_ADD    = 3'd1,
      ALU_SUB    = 3'd2,
      ALU_AND    = 3'd3,
      ALU_OR     = 3'd4,
      ALU_XOR    = 3'd5,
      ALU_PASS_A = 3'd6
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_FETCH2 = 3'd3,
      ST_HALT   = 3'd4
   } ctrl_state_e;

endpackage

// File: rtl/accu_decoder.sv
// Combinational opcode decoder: maps an opcode nibble to the execute-cycle
// controls plus the flags the sequencer needs to pick its next state.
module accu_decoder
   import accu_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output alu_op_e          alu_op,
   output logic             acc_we,
   output logic             reg_ce,
   output logic             two_byte,
   output logic             is_halt,
   output logic             illegal
);

   // Opcode table; undefined opcodes (A..E) only raise illegal and act as NOP.
   always_comb begin
      alu_op   = ALU_PASS_B;
      acc_we   = 1'b0;
      reg_ce   = 1'b0;
      two_byte = 1'b0;
      is_halt  = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OP_NOP: ;
         OP_LD:  begin acc_we = 1'b1; alu_op = ALU_PASS_B; end
         OP_ST:  reg_ce = 1'b1;
         OP_ADD: begin acc_we = 1'b1; alu_op = ALU_ADD; end
         OP_SUB: begin acc_we = 1'b1; alu_op = ALU_SUB; end
         OP_AND: begin acc_we = 1'b1; alu_op = ALU_AND; end
         OP_OR:  begin acc_we = 1'b1; alu_op = ALU_OR;  end
         OP_XOR: begin acc_we = 1'b1; alu_op = ALU_XOR; end
         OP_JMP: two_byte = 1'b1;
         OP_JZ:  two_byte = 1'b1;
         OP_HLT: is_halt = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/accu_control_unit.sv
// Fetch/execute sequencer for the accumulator core: owns the program counter,
// fetches one- and two-byte instructions and drives register file, ALU and
// accumulator controls. All control outputs are registered.
module accu_control_unit
   import accu_pkg::*;
#(
   parameter int PC_W   = 8,
   parameter int DATA_W = 8
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  instr_req,
   output logic [PC_W-1:0]       pc,
   input  logic                  instr_valid,
   input  logic [DATA_W-1:0]     instr,
   input  logic                  zero_flag,
   output logic [REG_ADDR_W-1:0] register_address,
   output logic                  reg_ce,
   output logic                  acc_we,
   output logic [2:0]            alu_op,
   output logic                  illegal,
   output logic                  halted
);

   ctrl_state_e state;

   // Only the opcode and register fields of the instruction register are
   // kept; bits [3:2] carry no meaning.
   logic [OPC_W-1:0]      ir_opc;
   logic [REG_ADDR_W-1:0] ir_reg;

   alu_op_e   dec_alu_op;
   logic      dec_acc_we;
   logic      dec_reg_ce;
   logic      dec_two_byte;
   logic      dec_is_halt;
   logic      dec_illegal;

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] jump_target;
   logic            take_jump;

   // Decode straight from the fetch bus so EXEC controls can be registered
   // on the same edge that loads the instruction register.
   accu_decoder u_decoder (
      .opcode   (instr[7:4]),
      .alu_op   (dec_alu_op),
      .acc_we   (dec_acc_we),
      .reg_ce   (dec_reg_ce),
      .two_byte (dec_two_byte),
      .is_halt  (dec_is_halt),
      .illegal  (dec_illegal)
   );

   assign pc_inc           = pc + PC_W'(1);
   assign jump_target      = PC_W'(instr);
   assign take_jump        = (ir_opc == OP_JMP) || ((ir_opc == OP_JZ) && zero_flag);
   assign register_address = ir_reg;

   // Sequencer FSM with registered outputs; outputs are set for the state
   // being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pc        <= '0;
         ir_opc    <= '0;
         ir_reg    <= '0;
         instr_req <= 1'b0;
         reg_ce    <= 1'b0;
         acc_we    <= 1'b0;
         alu_op    <= ALU_PASS_B;
         illegal   <= 1'b0;
         halted    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state     <= ST_FETCH;
               instr_req <= 1'b1;
            end
            ST_FETCH: begin
               if (instr_valid) begin
                  ir_opc <= instr[7:4];
                  ir_reg <= instr[1:0];
                  pc     <= pc_inc;
                  if (dec_two_byte) begin
                     // Request stays up for the target byte at pc+1.
                     state <= ST_FETCH2;
                  end else if (dec_is_halt) begin
                     state     <= ST_HALT;
                     instr_req <= 1'b0;
                     halted    <= 1'b1;
                  end else begin
                     state     <= ST_EXEC;
                     instr_req <= 1'b0;
                     acc_we    <= dec_acc_we;
                     reg_ce    <= dec_reg_ce;
                     illegal   <= dec_illegal;
                     alu_op    <= dec_alu_op;
                  end
               end
            end
            ST_EXEC: begin
               state     <= ST_FETCH;
               instr_req <= 1'b1;
               acc_we    <= 1'b0;
               reg_ce    <= 1'b0;
               illegal   <= 1'b0;
               alu_op    <= ALU_PASS_B;
            end
            ST_FETCH2: begin
               if (instr_valid) begin
                  state <= ST_FETCH;
                  pc    <= take_jump ? jump_target : pc_inc;
               end
            end
            ST_HALT: ;
            default: begin
               state     <= ST_IDLE;
               instr_req <= 1'b0;
               acc_we    <= 1'b0;
               reg_ce    <= 1'b0;
               illegal   <= 1'b0;
               alu_op    <= ALU_PASS_B;
               halted    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accu_control_unit.sv
// Directed bench for accu_control_unit with a zero-wait instruction memory
// that can be stalled from the stimulus.
module tb_accu_control_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       instr_req;
   logic [7:0] pc;
   logic       instr_valid;
   logic [7:0] instr;
   logic       zero_flag = 1'b0;
   logic [1:0] register_address;
   logic       reg_ce;
   logic       acc_we;
   logic [2:0] alu_op;
   logic       illegal;
   logic       halted;

   logic [7:0] mem [0:255];
   logic       stall = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign instr       = mem[pc];
   assign instr_valid = instr_req & ~stall;

   accu_control_unit #(.PC_W(8), .DATA_W(8)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .instr_req        (instr_req),
      .pc               (pc),
      .instr_valid      (instr_valid),
      .instr            (instr),
      .zero_flag        (zero_flag),
      .register_address (register_address),
      .reg_ce           (reg_ce),
      .acc_we           (acc_we),
      .alu_op           (alu_op),
      .illegal          (illegal),
      .halted           (halted)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic req, input logic [7:0] epc,
                             input logic [1:0] ra, input logic ce, input logic we,
                             input logic [2:0] op, input logic ill, input logic hlt);
      check({tag, " instr_req"}, 32'(instr_req), 32'(req));
      check({tag, " pc"}, 32'(pc), 32'(epc));
      check({tag, " register_address"}, 32'(register_address), 32'(ra));
      check({tag, " reg_ce"}, 32'(reg_ce), 32'(ce));
      check({tag, " acc_we"}, 32'(acc_we), 32'(we));
      check({tag, " alu_op"}, 32'(alu_op), 32'(op));
      check({tag, " illegal"}, 32'(illegal), 32'(ill));
      check({tag, " halted"}, 32'(halted), 32'(hlt));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h11;  // LD R1
      mem[8'h01] = 8'h23;  // ST R3
      mem[8'h02] = 8'h00;  // NOP
      mem[8'h03] = 8'h80;  // JMP
      mem[8'h04] = 8'h10;  //   -> 0x10
      mem[8'h10] = 8'h90;  // JZ (not taken)
      mem[8'h11] = 8'h40;
      mem[8'h12] = 8'h90;  // JZ (taken)
      mem[8'h13] = 8'h40;
      mem[8'h40] = 8'h35;  // ADD R1
      mem[8'h41] = 8'hB3;  // illegal
      mem[8'h42] = 8'h80;  // JMP
      mem[8'h43] = 8'hFF;  //   -> 0xFF
      mem[8'hFF] = 8'h00;  // NOP, pc wraps

      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      expect_out("reset", 0, 8'h00, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #1 expect_out("idle", 0, 8'h00, 0, 0, 0, 0, 0, 0);

      step(); expect_out("fetch LD", 1, 8'h00, 0, 0, 0, 0, 0, 0);
      step(); expect_out("exec LD", 0, 8'h01, 1, 0, 1, 0, 0, 0);
      mem[8'h00] = 8'hF0;  // HLT on the wrapped pass
      step(); expect_out("fetch ST", 1, 8'h01, 1, 0, 0, 0, 0, 0);
      step(); expect_out("exec ST", 0, 8'h02, 3, 1, 0, 0, 0, 0);
      step(); expect_out("after ST", 1, 8'h02, 3, 0, 0, 0, 0, 0);
      step(); expect_out("exec NOP", 0, 8'h03, 0, 0, 0, 0, 0, 0);
      step(); expect_out("fetch JMP", 1, 8'h03, 0, 0, 0, 0, 0, 0);
      step(); expect_out("fetch2 JMP", 1, 8'h04, 0, 0, 0, 0, 0, 0);
      step(); expect_out("JMP target", 1, 8'h10, 0, 0, 0, 0, 0, 0);
      step(); expect_out("fetch2 JZ nt", 1, 8'h11, 0, 0, 0, 0, 0, 0);
      step(); expect_out("JZ not taken", 1, 8'h12, 0, 0, 0, 0, 0, 0);
      step(); expect_out("fetch2 JZ t", 1, 8'h13, 0, 0, 0, 0, 0, 0);
      zero_flag = 1'b1;
      step();
      zero_flag = 1'b0;   // must already have been sampled
      expect_out("JZ taken", 1, 8'h40, 0, 0, 0, 0, 0, 0);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); expect_out("stall", 1, 8'h40, 0, 0, 0, 0, 0, 0);
      end
      stall = 1'b0;
      step(); expect_out("exec ADD", 0, 8'h41, 1, 0, 1, 1, 0, 0);
      step(); expect_out("fetch illegal", 1, 8'h41, 1, 0, 0, 0, 0, 0);
      step(); expect_out("exec illegal", 0, 8'h42, 3, 0, 0, 0, 1, 0);
      step(); expect_out("after illegal", 1, 8'h42, 3, 0, 0, 0, 0, 0);
      step(); expect_out("fetch2 JMP FF", 1, 8'h43, 0, 0, 0, 0, 0, 0);
      step(); expect_out("JMP FF", 1, 8'hFF, 0, 0, 0, 0, 0, 0);
      step(); expect_out("NOP wrap", 0, 8'h00, 0, 0, 0, 0, 0, 0);
      step(); expect_out("fetch HLT", 1, 8'h00, 0, 0, 0, 0, 0, 0);
      step(); expect_out("halt entry", 0, 8'h01, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         step(); expect_out("halt hold", 0, 8'h01, 0, 0, 0, 0, 0, 1);
      end

      mem[8'h00] = 8'h20;  // ST R0
      rst_n = 1'b0;
      #1 expect_out("reset from halt", 0, 8'h00, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(); expect_out("fetch ST R0", 1, 8'h00, 0, 0, 0, 0, 0, 0);
      step(); expect_out("exec ST R0", 0, 8'h01, 0, 1, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1 expect_out("reset in exec", 0, 8'h00, 0, 0, 0, 0, 0, 0);
      step(); expect_out("reset held", 0, 8'h00, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step(); expect_out("refetch", 1, 8'h00, 0, 0, 0, 0, 0, 0);
      step(); expect_out("re-exec ST R0", 0, 8'h01, 0, 1, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
